// File: rtl/compositor_pkg.sv
// ---------------------------------------------------------------------------
// compositor_pkg
// Constants and types shared by the layer compositor and its palette:
//   PAL_ENTRIES      number of entries in the default palette table
//   TERRAIN_IDX      palette index used for terrain pixels
//   BACKDROP_IDX     palette index used when nothing covers the pixel
//   FADE_LEVEL_FULL  fade level meaning full brightness (scale 8/8)
//   DEFAULT_PALETTE  reset contents of the palette (RGB888, index 0 first)
//   src_tag_e        pixel source carried down the pipeline
//   fade_state_e     fade sequencer states
// ---------------------------------------------------------------------------
package compositor_pkg;

    localparam int PAL_ENTRIES  = 32;
    localparam int TERRAIN_IDX  = 22;
    localparam int BACKDROP_IDX = 24;

    localparam logic [3:0] FADE_LEVEL_FULL = 4'd8;

    localparam logic [23:0] DEFAULT_PALETTE [PAL_ENTRIES] = '{
        24'h23405B, 24'hFFFFFF, 24'h000000, 24'hE43B44,
        24'hF77622, 24'hFEAE34, 24'hFEE761, 24'h2FBDA1,
        24'h3E8948, 24'h265C42, 24'h193C3E, 24'h124E89,
        24'h0099DB, 24'h2CE8F5, 24'hC0CBDC, 24'h8B9BB4,
        24'h5A6988, 24'h3A4466, 24'h262B44, 24'hFF0044,
        24'h68386C, 24'hB55088, 24'h844731, 24'hF6757A,
        24'h0055AA, 24'hE8B796, 24'hC28569, 24'hA22633,
        24'h733E39, 24'h3E2731, 24'hEAD4AA, 24'hFBAF3A
    };

    typedef enum logic [1:0] {
        SRC_BLANK    = 2'd0,
        SRC_BACKDROP = 2'd1,
        SRC_TERRAIN  = 2'd2,
        SRC_LAYER    = 2'd3
    } src_tag_e;

    typedef enum logic [1:0] {
        FADE_IDLE = 2'd0,
        FADE_OUT  = 2'd1,
        FADE_DARK = 2'd2,
        FADE_IN   = 2'd3
    } fade_state_e;

endpackage

// File: rtl/palette_regfile.sv
// ---------------------------------------------------------------------------
// palette_regfile
// Flop-based colour palette, loaded with DEFAULT_PALETTE on reset.
// One synchronous write port, one combinational read port; a read of an
// entry in the same cycle it is written returns the previous contents.
//   clk       clock
//   reset_n   asynchronous active-low reset
//   we_i      write enable
//   waddr_i   write index
//   wdata_i   write colour (RGB888)
//   raddr_i   read index
//   rdata_o   read colour (RGB888)
// ---------------------------------------------------------------------------
module palette_regfile
    import compositor_pkg::*;
#(
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [23:0]      wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output logic [23:0]      rdata_o
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [23:0] mem_q [DEPTH];

    // Palette storage: reset image wraps if the table is wider than the default.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= DEFAULT_PALETTE[i % PAL_ENTRIES];
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end else begin
            mem_q <= mem_q;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/layer_compositor.sv
// ---------------------------------------------------------------------------
// layer_compositor
// Three-stage pixel compositor: picks the highest-priority source among the
// sprite layers, the terrain bitmap and the backdrop, fetches the sprite
// palette index from an external synchronous RAM, then looks the colour up
// in the palette. Optional fade-to-black sequencer is built only when the
// macro COMPOSITOR_FADE_EN is defined.
//   clk, reset_n                 clock, asynchronous active-low reset
//   DrawY                        current pixel row
//   terrain_data                 terrain column bitmap, one bit per row
//   layer_draw, layer_addr       per-layer coverage flags and packed addresses
//   blank                        high in the visible area
//   frame_start                  one-cycle pulse per frame
//   sprite_addr / sprite_data    sprite RAM read address / returned index
//   pal_we, pal_waddr, pal_wdata palette write port
//   fade_req / fade_busy         fade request / fade in progress
//   Red, Green, Blue, blank_out  registered colour and aligned blank
// ---------------------------------------------------------------------------
module layer_compositor
    import compositor_pkg::*;
#(
    parameter int NUM_LAYERS   = 4,
    parameter int ADDR_W       = 18,
    parameter int IDX_W        = 5,
    parameter int TERRAIN_PRIO = 2,
    parameter int FADE_FRAMES  = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [9:0]                   DrawY,
    input  logic [479:0]                 terrain_data,
    input  logic [NUM_LAYERS-1:0]        layer_draw,
    input  logic [NUM_LAYERS*ADDR_W-1:0] layer_addr,
    input  logic                         blank,
    input  logic                         frame_start,
    output logic [ADDR_W-1:0]            sprite_addr,
    input  logic [IDX_W-1:0]             sprite_data,
    input  logic                         pal_we,
    input  logic [IDX_W-1:0]             pal_waddr,
    input  logic [23:0]                  pal_wdata,
    input  logic                         fade_req,
    output logic                         fade_busy,
    output logic [7:0]                   Red,
    output logic [7:0]                   Green,
    output logic [7:0]                   Blue,
    output logic                         blank_out
);

    // ---------------- Stage 1: priority resolution ----------------
    logic              terrain_s;
    logic              found_s;
    src_tag_e          tag1_d;
    logic [ADDR_W-1:0] sprite_addr_d;
    src_tag_e          tag1_q;
    src_tag_e          tag2_q;
    logic [ADDR_W-1:0] sprite_addr_q;
    logic [2:0]        blank_dly_q;

    // Rows past the bitmap never show terrain.
    assign terrain_s = (DrawY < 10'd480) ? terrain_data[DrawY[8:0]] : 1'b0;

    // Walk priority slots low to high; terrain occupies the slot just ahead
    // of layer TERRAIN_PRIO (or after every layer when it equals NUM_LAYERS).
    always_comb begin
        found_s       = 1'b0;
        tag1_d        = SRC_BACKDROP;
        sprite_addr_d = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (!found_s && (i == TERRAIN_PRIO) && terrain_s) begin
                found_s = 1'b1;
                tag1_d  = SRC_TERRAIN;
            end else begin
                found_s = found_s;
            end
            if (!found_s && layer_draw[i]) begin
                found_s       = 1'b1;
                tag1_d        = SRC_LAYER;
                sprite_addr_d = layer_addr[i*ADDR_W +: ADDR_W];
            end else begin
                found_s = found_s;
            end
        end
        if (!found_s && (TERRAIN_PRIO >= NUM_LAYERS) && terrain_s) begin
            tag1_d = SRC_TERRAIN;
        end else begin
            tag1_d = tag1_d;
        end
        if (!blank) begin
            tag1_d        = SRC_BLANK;
            sprite_addr_d = '0;
        end else begin
            tag1_d = tag1_d;
        end
    end

    // Pipeline registers for stages 1 and 2 plus the blank delay line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sprite_addr_q <= '0;
            tag1_q        <= SRC_BLANK;
            tag2_q        <= SRC_BLANK;
            blank_dly_q   <= 3'b000;
        end else begin
            sprite_addr_q <= sprite_addr_d;
            tag1_q        <= tag1_d;
            tag2_q        <= tag1_q;
            blank_dly_q   <= {blank_dly_q[1:0], blank};
        end
    end

    assign sprite_addr = sprite_addr_q;
    assign blank_out   = blank_dly_q[2];

    // ---------------- Stage 2: index select ----------------
    logic [IDX_W-1:0] idx_s;
    logic [23:0]      pal_rdata_s;

    // sprite_data is the RAM reply to the address registered one cycle earlier.
    always_comb begin
        case (tag2_q)
            SRC_LAYER:    idx_s = sprite_data;
            SRC_TERRAIN:  idx_s = IDX_W'(TERRAIN_IDX);
            SRC_BACKDROP: idx_s = IDX_W'(BACKDROP_IDX);
            default:      idx_s = IDX_W'(BACKDROP_IDX);
        endcase
    end

    palette_regfile #(
        .IDX_W (IDX_W)
    ) u_palette (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (pal_we),
        .waddr_i (pal_waddr),
        .wdata_i (pal_wdata),
        .raddr_i (idx_s),
        .rdata_o (pal_rdata_s)
    );

    // ---------------- Stage 3: fade and output register ----------------
    logic [23:0] rgb_s;
    logic [23:0] rgb_q;

`ifdef COMPOSITOR_FADE_EN
    localparam int CNT_W = (FADE_FRAMES > 1) ? $clog2(FADE_FRAMES) : 1;

    fade_state_e      fade_state_q;
    logic [3:0]       level_q;
    logic [CNT_W-1:0] frame_cnt_q;
    logic             fade_busy_q;
    logic             level_step_s;
    logic [10:0]      r_mul_s;
    logic [10:0]      g_mul_s;
    logic [10:0]      b_mul_s;

    // A level step happens on the frame_start that completes FADE_FRAMES frames.
    assign level_step_s = frame_start && (frame_cnt_q == CNT_W'(FADE_FRAMES - 1));

    // Fade sequencer; fade_req is only honoured while the level is at rest.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fade_state_q <= FADE_IDLE;
            level_q      <= FADE_LEVEL_FULL;
            frame_cnt_q  <= '0;
            fade_busy_q  <= 1'b0;
        end else begin
            case (fade_state_q)
                FADE_IDLE, FADE_DARK: begin
                    frame_cnt_q <= '0;
                    if (fade_req) begin
                        fade_state_q <= (fade_state_q == FADE_IDLE) ? FADE_OUT : FADE_IN;
                        fade_busy_q  <= 1'b1;
                    end
                end
                FADE_OUT, FADE_IN: begin
                    if (level_step_s) begin
                        frame_cnt_q <= '0;
                        if (fade_state_q == FADE_OUT) begin
                            level_q <= level_q - 4'd1;
                            if (level_q == 4'd1) begin
                                fade_state_q <= FADE_DARK;
                                fade_busy_q  <= 1'b0;
                            end
                        end else begin
                            level_q <= level_q + 4'd1;
                            if (level_q == 4'd7) begin
                                fade_state_q <= FADE_IDLE;
                                fade_busy_q  <= 1'b0;
                            end
                        end
                    end else if (frame_start) begin
                        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    fade_state_q <= FADE_IDLE;
                    level_q      <= FADE_LEVEL_FULL;
                    frame_cnt_q  <= '0;
                    fade_busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign fade_busy = fade_busy_q;

    // Each channel scaled by level/8; level 8 is an exact pass-through.
    always_comb begin
        r_mul_s = {3'b000, pal_rdata_s[23:16]} * {7'b0000000, level_q};
        g_mul_s = {3'b000, pal_rdata_s[15:8]}  * {7'b0000000, level_q};
        b_mul_s = {3'b000, pal_rdata_s[7:0]}   * {7'b0000000, level_q};
        rgb_s   = {r_mul_s[10:3], g_mul_s[10:3], b_mul_s[10:3]};
    end
`else
    logic unused_fade_s;

    assign unused_fade_s = ^{fade_req, frame_start, FADE_LEVEL_FULL};
    assign fade_busy     = 1'b0;
    assign rgb_s         = pal_rdata_s;
`endif

    // Output colour register; blanked pixels are forced black.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q <= 24'h000000;
        end else if (tag2_q == SRC_BLANK) begin
            rgb_q <= 24'h000000;
        end else begin
            rgb_q <= rgb_s;
        end
    end

    assign Red   = rgb_q[23:16];
    assign Green = rgb_q[15:8];
    assign Blue  = rgb_q[7:0];

endmodule

// File: tb/tb_layer_compositor.sv
module tb_layer_compositor;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [9:0]    DrawY;
    logic [479:0]  terrain_data;
    logic [3:0]    layer_draw;
    logic [71:0]   layer_addr;
    logic          blank;
    logic          frame_start;
    logic [17:0]   sprite_addr;
    logic [4:0]    sprite_data;
    logic          pal_we;
    logic [4:0]    pal_waddr;
    logic [23:0]   pal_wdata;
    logic          fade_req;
    logic          fade_busy;
    logic [7:0]    Red, Green, Blue;
    logic          blank_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    layer_compositor #(
        .NUM_LAYERS   (4),
        .ADDR_W       (18),
        .IDX_W        (5),
        .TERRAIN_PRIO (2),
        .FADE_FRAMES  (1)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .DrawY        (DrawY),
        .terrain_data (terrain_data),
        .layer_draw   (layer_draw),
        .layer_addr   (layer_addr),
        .blank        (blank),
        .frame_start  (frame_start),
        .sprite_addr  (sprite_addr),
        .sprite_data  (sprite_data),
        .pal_we       (pal_we),
        .pal_waddr    (pal_waddr),
        .pal_wdata    (pal_wdata),
        .fade_req     (fade_req),
        .fade_busy    (fade_busy),
        .Red          (Red),
        .Green        (Green),
        .Blue         (Blue),
        .blank_out    (blank_out)
    );

    // Synchronous sprite RAM model: a few populated addresses.
    always @(posedge clk) begin
        case (sprite_addr)
            18'h00100: sprite_data <= 5'd7;
            18'h00200: sprite_data <= 5'd3;
            18'h00300: sprite_data <= 5'd31;
            default:   sprite_data <= 5'd0;
        endcase
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic frame_pulse();
        frame_start = 1'b1;
        step(1);
        frame_start = 1'b0;
        step(1);
    endtask

    initial begin
        reset_n      = 1'b0;
        DrawY        = 10'd0;
        terrain_data = '0;
        layer_draw   = 4'b0000;
        layer_addr   = '0;
        blank        = 1'b1;
        frame_start  = 1'b0;
        pal_we       = 1'b0;
        pal_waddr    = 5'd0;
        pal_wdata    = 24'h000000;
        fade_req     = 1'b0;

        // Reset state
        step(3);
        check("reset_rgb",   {8'h00, Red, Green, Blue}, 32'h000000);
        check("reset_blank", {31'd0, blank_out}, 32'd0);
        check("reset_addr",  {14'd0, sprite_addr}, 32'h0);
        check("reset_busy",  {31'd0, fade_busy}, 32'd0);

        // Backdrop after reset
        reset_n = 1'b1;
        step(3);
        check("backdrop_rgb",   {8'h00, Red, Green, Blue}, 32'h0055AA);
        check("backdrop_blank", {31'd0, blank_out}, 32'd1);

        // Layers 0 and 2 active: layer 0 wins
        layer_draw = 4'b0101;
        layer_addr[0*18 +: 18] = 18'h00100;
        layer_addr[1*18 +: 18] = 18'h00300;
        layer_addr[2*18 +: 18] = 18'h00200;
        layer_addr[3*18 +: 18] = 18'h00100;
        step(1);
        check("l0_addr", {14'd0, sprite_addr}, 32'h00100);
        step(2);
        check("l0_rgb", {8'h00, Red, Green, Blue}, 32'h2FBDA1);

        // Terrain ahead of layer 2
        layer_draw = 4'b0100;
        DrawY = 10'd100;
        terrain_data[100] = 1'b1;
        terrain_data[479] = 1'b1;
        step(1);
        check("terr_addr", {14'd0, sprite_addr}, 32'h0);
        step(2);
        check("terr_rgb", {8'h00, Red, Green, Blue}, 32'h844731);

        // Last bitmap row still shows terrain
        DrawY = 10'd479;
        step(3);
        check("terr479_rgb", {8'h00, Red, Green, Blue}, 32'h844731);

        // Row 480 has no terrain: layer 2 shows
        DrawY = 10'd480;
        step(1);
        check("y480_addr", {14'd0, sprite_addr}, 32'h00200);
        step(2);
        check("y480_rgb", {8'h00, Red, Green, Blue}, 32'hE43B44);

        // Layer 1 beats terrain, terrain beats layer 3
        DrawY = 10'd100;
        layer_draw = 4'b0010;
        step(3);
        check("l1_over_terr", {8'h00, Red, Green, Blue}, 32'hFBAF3A);
        layer_draw = 4'b1000;
        step(3);
        check("terr_over_l3", {8'h00, Red, Green, Blue}, 32'h844731);

        // Palette write: same-cycle lookup old, next cycle new
        DrawY = 10'd0;
        layer_draw = 4'b0001;
        step(3);
        check("pre_write", {8'h00, Red, Green, Blue}, 32'h2FBDA1);
        pal_we = 1'b1;
        pal_waddr = 5'd7;
        pal_wdata = 24'h123456;
        step(1);
        pal_we = 1'b0;
        check("write_old", {8'h00, Red, Green, Blue}, 32'h2FBDA1);
        step(1);
        check("write_new", {8'h00, Red, Green, Blue}, 32'h123456);

        // Blanking: output black and blank_out follows 3 cycles later
        blank = 1'b0;
        step(2);
        check("blank_dly2", {31'd0, blank_out}, 32'd1);
        step(1);
        check("blank_dly3", {31'd0, blank_out}, 32'd0);
        check("blank_rgb", {8'h00, Red, Green, Blue}, 32'h000000);
        blank = 1'b1;
        step(3);
        check("unblank_rgb", {8'h00, Red, Green, Blue}, 32'h123456);

        // Asynchronous reset clears outputs and restores palette
        reset_n = 1'b0;
        #1;
        check("async_rgb",  {8'h00, Red, Green, Blue}, 32'h000000);
        check("async_addr", {14'd0, sprite_addr}, 32'h0);
        step(1);
        reset_n = 1'b1;
        step(3);
        check("pal_restored", {8'h00, Red, Green, Blue}, 32'h2FBDA1);

`ifdef COMPOSITOR_FADE_EN
        pal_we = 1'b1;
        pal_waddr = 5'd7;
        pal_wdata = 24'hFFFFFF;
        step(1);
        pal_we = 1'b0;
        step(3);
        check("fade_white", {8'h00, Red, Green, Blue}, 32'hFFFFFF);
        fade_req = 1'b1;
        step(1);
        fade_req = 1'b0;
        check("fade_busy_on", {31'd0, fade_busy}, 32'd1);
        for (int i = 0; i < 4; i++) frame_pulse();
        step(1);
        check("fade_lvl4", {8'h00, Red, Green, Blue}, 32'h7F7F7F);
        fade_req = 1'b1;
        step(1);
        fade_req = 1'b0;
        for (int i = 0; i < 3; i++) frame_pulse();
        check("fade_busy_7", {31'd0, fade_busy}, 32'd1);
        frame_pulse();
        check("fade_busy_8", {31'd0, fade_busy}, 32'd0);
        step(1);
        check("fade_dark", {8'h00, Red, Green, Blue}, 32'h000000);
        fade_req = 1'b1;
        step(1);
        fade_req = 1'b0;
        check("fade_in_busy", {31'd0, fade_busy}, 32'd1);
        for (int i = 0; i < 8; i++) frame_pulse();
        step(1);
        check("fade_in_done", {31'd0, fade_busy}, 32'd0);
        check("fade_in_rgb", {8'h00, Red, Green, Blue}, 32'hFFFFFF);
        fade_req = 1'b1;
        step(1);
        fade_req = 1'b0;
        for (int i = 0; i < 2; i++) frame_pulse();
        step(1);
        check("fade_lvl6", {8'h00, Red, Green, Blue}, 32'hBFBFBF);
        reset_n = 1'b0;
        #1;
        check("fade_rst_busy", {31'd0, fade_busy}, 32'd0);
        step(1);
        reset_n = 1'b1;
        step(3);
        check("fade_rst_rgb", {8'h00, Red, Green, Blue}, 32'h2FBDA1);
        check("fade_rst_idle", {31'd0, fade_busy}, 32'd0);
`else
        fade_req = 1'b1;
        step(1);
        fade_req = 1'b0;
        check("nofade_busy", {31'd0, fade_busy}, 32'd0);
        for (int i = 0; i < 3; i++) frame_pulse();
        check("nofade_busy2", {31'd0, fade_busy}, 32'd0);
        check("nofade_rgb", {8'h00, Red, Green, Blue}, 32'h2FBDA1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/layer_compositor.md
LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 Parameter NUM_LAYERS, default 4, SHALL set the number of sprite layers (1..8).
REQ-002 Parameter ADDR_W, default 18, SHALL set the sprite RAM address width.
REQ-003 Parameter IDX_W, default 5, SHALL set the palette index width (2**IDX_W entries).
REQ-004 Parameter TERRAIN_PRIO, default 2, SHALL set the priority slot of the terrain layer (0..NUM_LAYERS).
REQ-005 Parameter FADE_FRAMES, default 4, SHALL set the number of frames per fade step (>=1).
REQ-006 clk  in  1  SHALL be the single clock; all state on its rising edge.
REQ-007 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-008 DrawY  in  10  SHALL be the current pixel row.
REQ-009 terrain_data  in  480  SHALL be the terrain column bitmap, one bit per row.
REQ-010 layer_draw  in  NUM_LAYERS  SHALL flag, per layer, that the layer covers this pixel.
REQ-011 layer_addr  in  NUM_LAYERS*ADDR_W  SHALL carry the packed per-layer sprite RAM addresses, layer 0 in the LSBs.
REQ-012 blank  in  1  SHALL be high during the visible area and low during blanking.
REQ-013 frame_start  in  1  SHALL pulse for one cycle per frame.
REQ-014 sprite_addr  out  ADDR_W  SHALL be the registered read address to the synchronous sprite RAM.
REQ-015 sprite_data  in  IDX_W  SHALL be the palette index returned one cycle after sprite_addr.
REQ-016 pal_we / pal_waddr / pal_wdata  in  1/IDX_W/24  SHALL form the palette write port.
REQ-017 fade_req  in  1  SHALL be a one-cycle fade request.
REQ-018 fade_busy  out  1  SHALL be high while a fade is in progress.
REQ-019 Red / Green / Blue  out  8 each  SHALL be the registered pixel color.
REQ-020 blank_out  out  1  SHALL be blank delayed to align with Red/Green/Blue.

Function
REQ-021 Priority SHALL be: lowest-numbered active layer first, with terrain inserted ahead of layer TERRAIN_PRIO, then backdrop.
REQ-022 Terrain SHALL be active when DrawY<480 and terrain_data[DrawY]=1; for DrawY>=480 it SHALL be inactive.
REQ-023 Stage 1 SHALL register the sprite_addr of the winning layer (0 if none) and a source tag (layer/terrain/backdrop/blank).
REQ-024 Stage 2 SHALL select the index: sprite_data for a layer, TERRAIN_IDX for terrain, BACKDROP_IDX for backdrop.
REQ-025 Stage 3 SHALL register the palette lookup (and fade) into Red/Green/Blue; total latency SHALL be exactly 3 cycles, fully pipelined, one pixel per cycle.
REQ-026 blank=0 SHALL force the output to 24'h000000, with blank_out following blank exactly 3 cycles later.
REQ-027 A palette write at cycle N SHALL be visible from cycle N+1; a lookup of the same entry in cycle N SHALL return the old value.

Reset
REQ-028 Asserting reset_n SHALL immediately clear sprite_addr, Red/Green/Blue, blank_out, fade_busy and the pipeline tags.
REQ-029 Reset SHALL load the palette with DEFAULT_PALETTE, the fade level with 8, and the fade FSM with IDLE, including mid-fade.

Configuration
REQ-030 With COMPOSITOR_FADE_EN defined, the fade FSM (IDLE->FADE_OUT->DARK->FADE_IN->IDLE) SHALL be built. fade_req SHALL advance IDLE or DARK, and SHALL be ignored in FADE_OUT and FADE_IN. The level SHALL step by 1 every FADE_FRAMES frame_start pulses. FADE_OUT SHALL enter DARK at level 0, and FADE_IN SHALL enter IDLE at level 8. Each output channel SHALL be (channel*level)>>3.
REQ-031 Without COMPOSITOR_FADE_EN, the ports SHALL be unchanged, fade_req SHALL be ignored, fade_busy SHALL be tied to 0, and no multiplier SHALL be built.

Structure
REQ-032 Package compositor_pkg SHALL hold DEFAULT_PALETTE (32x24, 0:23405B ... 22:844731, 24:0055AA, 31:FBAF3A), TERRAIN_IDX=22, BACKDROP_IDX=24, the source-tag enum and the fade state enum.
REQ-033 The palette SHALL be the sub-module palette_regfile (reset-initialised, one write port, one read port).

Verification
REQ-034 After reset, with blank=1, layer_draw=0 and terrain off, the output 3 cycles later SHALL be RGB=0055AA; Red/Green/Blue SHALL read 0 during reset.
REQ-035 With layer_draw=4'b0101, addr0=18'h00100 and addr2=18'h00200, sprite_addr SHALL be 00100 next cycle; sprite_data=7 SHALL give RGB=2FBDA1 at +3 cycles.
REQ-036 With layer_draw=4'b0100, DrawY=100 and terrain_data[100]=1, the output SHALL be 844731; with DrawY=480 the output SHALL come from layer 2.
REQ-037 A write of pal 7=123456 followed by an index-7 pixel SHALL produce 123456; a subsequent reset SHALL restore 2FBDA1.
REQ-038 With FADE_EN, FADE_FRAMES=1 and fade_req, fade_busy SHALL stay high for 8 frames; at level 4, FFFFFF SHALL become 7F7F7F; DARK SHALL give 000000.
REQ-039 Blank and reset: blank=0 SHALL give 000000 with blank_out=0 at +3 cycles; reset mid-FADE_OUT SHALL return to IDLE at full brightness.
